// File: rtl/mem_access_guard_if.sv
// Bundle between the CPU native memory port, the SRAM port and the access guard.
// Ports: CPU request/response (valid/ready, addr, wdata, wstrb, rdata, is_inst, pc_addr),
//        stall request (inform_cpu_wait), SRAM (mem_wen, mem_addr, mem_wdata, mem_rdata), fault.
// slave = guard's view of the bundle; master = the CPU/SRAM side driving it.
interface mem_access_guard_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    is_inst;
  logic [31:0]             pc_addr;
  logic                    inform_cpu_wait;
  logic                    cpu_valid;
  logic                    cpu_ready;
  logic [21:0]             cpu_addr;
  logic [DATA_WIDTH-1:0]   cpu_wdata;
  logic [3:0]              cpu_wstrb;
  logic [DATA_WIDTH-1:0]   cpu_rdata;
  logic [3:0]              mem_wen;
  logic [21:0]             mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    fault;

  modport slave (
    input  is_inst, pc_addr, cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata,
    output inform_cpu_wait, cpu_ready, cpu_rdata, mem_wen, mem_addr, mem_wdata, fault
  );

  modport master (
    output is_inst, pc_addr, cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, mem_rdata,
    input  inform_cpu_wait, cpu_ready, cpu_rdata, mem_wen, mem_addr, mem_wdata, fault
  );
endinterface

// File: rtl/mem_access_guard.sv
// Purpose: memory protection unit between the CPU memory port and a 1-cycle SRAM;
//   loads a PC/data-range rule table from SRAM after reset, then checks every access.
// Latency: cpu_ready 2 cycles after cpu_valid is sampled; one access per 3 cycles.
// Backpressure: CPU stalled via inform_cpu_wait during table load; cpu_valid held until cpu_ready.
// Ports: clk, reset (sync, active-high); bus (mem_access_guard_if.slave) carries CPU + SRAM sides.
module mem_access_guard #(
  parameter int DATA_WIDTH     = 32,
  parameter int MPU_START_ADDR = 768,
  parameter int MPU_LEN        = 16
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_guard_if.slave   bus
);
  localparam int NUM_RULES = MPU_LEN / 4;
  localparam int KW        = $clog2(MPU_LEN + 1);
  localparam int IW        = $clog2(MPU_LEN);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_RESP, S_DONE} state_t;

  state_t                              state;
  logic [KW-1:0]                       load_k;
  logic [MPU_LEN-1:0][DATA_WIDTH-1:0]  cfg;
  logic                                allowed_q;

  logic [31:0] byte_addr;
  logic        is_write;
  logic        cfg_hit;
  logic        data_hit;
  logic        code_ok;
  logic        access_ok;

  assign byte_addr = {8'b0, bus.cpu_addr, 2'b00};
  assign is_write  = |bus.cpu_wstrb;
  assign cfg_hit   = (bus.cpu_addr >= 22'(MPU_START_ADDR)) &&
                     (bus.cpu_addr <  22'(MPU_START_ADDR + MPU_LEN));

  // A rule only guards its data window when both windows are non-empty.
  // The address must be reachable from the code window of at least one
  // rule that covers it; addresses outside every enabled rule are free.
  always_comb begin
    data_hit = 1'b0;
    code_ok  = 1'b0;
    for (int r = 0; r < NUM_RULES; r++) begin
      if ((cfg[IW'(4*r)]   < cfg[IW'(4*r+1)]) &&
          (cfg[IW'(4*r+2)] < cfg[IW'(4*r+3)]) &&
          (byte_addr >= cfg[IW'(4*r+2)]) && (byte_addr < cfg[IW'(4*r+3)])) begin
        data_hit = 1'b1;
        if ((bus.pc_addr >= cfg[IW'(4*r)]) && (bus.pc_addr < cfg[IW'(4*r+1)]))
          code_ok = 1'b1;
      end
    end
  end

  // Fetches bypass the check; the rule table itself is never writable.
  assign access_ok = bus.is_inst || (!(is_write && cfg_hit) && (!data_hit || code_ok));

  // SRAM side is driven combinationally so the SRAM samples the address in
  // the same cycle the state machine issues it; its registered read data then
  // lines up with the following cycle. Forced to idle values while in reset.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wen   = '0;
    bus.mem_wdata = '0;
    if (!reset) begin
      case (state)
        S_LOAD: begin
          if (load_k < KW'(MPU_LEN))
            bus.mem_addr = 22'(MPU_START_ADDR) + 22'(load_k);
        end
        S_IDLE: begin
          if (bus.cpu_valid) begin
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_wen   = access_ok ? bus.cpu_wstrb : 4'b0000;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_LOAD;
      load_k              <= '0;
      cfg                 <= '0;
      allowed_q           <= 1'b0;
      bus.cpu_ready       <= 1'b0;
      bus.cpu_rdata       <= '0;
      bus.fault           <= 1'b0;
      bus.inform_cpu_wait <= 1'b1;
    end else begin
      case (state)
        S_LOAD: begin
          // Word k-1 was addressed last cycle, so its data is on mem_rdata now.
          if (load_k != '0)
            cfg[IW'(load_k - KW'(1))] <= bus.mem_rdata;
          if (load_k == KW'(MPU_LEN)) begin
            state               <= S_IDLE;
            bus.inform_cpu_wait <= 1'b0;
          end else begin
            load_k <= load_k + KW'(1);
          end
        end
        S_IDLE: begin
          if (bus.cpu_valid) begin
            allowed_q <= access_ok;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          bus.cpu_ready <= 1'b1;
          bus.cpu_rdata <= allowed_q ? bus.mem_rdata : '0;
          if (!allowed_q)
            bus.fault <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          // Gives the CPU a cycle to drop cpu_valid before the next sample.
          bus.cpu_ready <= 1'b0;
          bus.cpu_rdata <= '0;
          state         <= S_IDLE;
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_guard.sv
// Directed bench for mem_access_guard: SRAM model, table load, allowed/denied
// accesses, config-region write protection, range boundaries and mid-access reset.
module tb_mem_access_guard;
  logic clk;
  logic reset;
  logic sram_init;
  int   checks;
  int   failures;

  logic [31:0] sram [1024];

  mem_access_guard_if #(.DATA_WIDTH(32)) bus ();

  mem_access_guard #(
    .DATA_WIDTH(32),
    .MPU_START_ADDR(768),
    .MPU_LEN(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: byte-enabled write, registered read (old data on collision).
  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 1024; i++) sram[i] <= 32'h0;
      sram[769]   <= 32'h0000_0100;
      sram[770]   <= 32'h0000_0800;
      sram[771]   <= 32'h0000_0900;
      sram[10'h010] <= 32'h1234_5678;
      sram[10'h210] <= 32'hCAFE_F00D;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_wen[b]) sram[bus.mem_addr[9:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    bus.mem_rdata <= sram[bus.mem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with reset high; leaves at the negedge of the first IDLE cycle.
  // A stray CPU write request is held during the load and must be ignored.
  task automatic load_phase(input string tag);
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 22'h300;
    bus.cpu_wstrb = 4'hF;
    bus.cpu_wdata = 32'h5555_AAAA;
    reset = 1'b0;
    for (int c = 0; c < 17; c++) begin
      #1;
      chk({tag, ".wait"}, bus.inform_cpu_wait, 1);
      chk({tag, ".ld_wen"}, bus.mem_wen, 0);
      if (c < 16) chk({tag, ".ld_addr"}, bus.mem_addr, 768 + c);
      if (c == 16) begin
        bus.cpu_valid = 1'b0;
        bus.cpu_wstrb = 4'h0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk({tag, ".wait_drop"}, bus.inform_cpu_wait, 0);
  endtask

  // Entered and left at an IDLE-cycle negedge.
  task automatic access(input string tag, input logic inst, input logic [31:0] pc,
                        input logic [21:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [3:0] exp_wen, input logic chk_rd,
                        input logic [31:0] exp_rd, input logic exp_fault);
    bus.is_inst   = inst;
    bus.pc_addr   = pc;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    bus.cpu_wstrb = ws;
    bus.cpu_valid = 1'b1;
    #1;
    chk({tag, ".wen"}, bus.mem_wen, exp_wen);
    chk({tag, ".maddr"}, bus.mem_addr, addr);
    chk({tag, ".mwdata"}, bus.mem_wdata, wd);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".rdy_early"}, bus.cpu_ready, 0);
    chk({tag, ".wen_resp"}, bus.mem_wen, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".rdy"}, bus.cpu_ready, 1);
    if (chk_rd) chk({tag, ".rdata"}, bus.cpu_rdata, exp_rd);
    chk({tag, ".fault"}, bus.fault, exp_fault);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".rdy_pulse"}, bus.cpu_ready, 0);
    bus.cpu_valid = 1'b0;
    bus.cpu_wstrb = 4'h0;
    bus.is_inst   = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    sram_init     = 1'b1;
    bus.is_inst   = 1'b0;
    bus.pc_addr   = 32'h0;
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = 22'h0;
    bus.cpu_wdata = 32'h0;
    bus.cpu_wstrb = 4'h0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sram_init = 1'b0;
    #1;
    chk("rst.ready", bus.cpu_ready, 0);
    chk("rst.rdata", bus.cpu_rdata, 0);
    chk("rst.wen", bus.mem_wen, 0);
    chk("rst.addr", bus.mem_addr, 0);
    chk("rst.wdata", bus.mem_wdata, 0);
    chk("rst.fault", bus.fault, 0);
    chk("rst.wait", bus.inform_cpu_wait, 1);
    @(negedge clk);

    load_phase("load1");

    // Rule 0: code [0x0,0x100), data [0x800,0x900) -> words 0x200..0x23F
    access("wr_ok", 0, 32'h40, 22'h200, 32'hDEAD_BEEF, 4'hF, 4'hF, 0, 32'h0, 0);
    chk("wr_ok.sram", sram[10'h200], 32'hDEAD_BEEF);
    access("rd_ok", 0, 32'h40, 22'h200, 32'h0, 4'h0, 4'h0, 1, 32'hDEAD_BEEF, 0);
    access("rd_free", 0, 32'h200, 22'h010, 32'h0, 4'h0, 4'h0, 1, 32'h1234_5678, 0);
    access("fetch", 1, 32'h200, 22'h210, 32'h0, 4'h0, 4'h0, 1, 32'hCAFE_F00D, 0);
    access("cfg_rd", 0, 32'h200, 22'd770, 32'h0, 4'h0, 4'h0, 1, 32'h0000_0800, 0);
    access("part_wr", 0, 32'h200, 22'h020, 32'hAAAA_5555, 4'h3, 4'h3, 0, 32'h0, 0);
    chk("part_wr.sram", sram[10'h020], 32'h0000_5555);
    access("cfg_wr", 0, 32'h40, 22'd769, 32'hFFFF_FFFF, 4'hF, 4'h0, 0, 32'h0, 1);
    chk("cfg_wr.sram", sram[769], 32'h0000_0100);
    access("sticky", 0, 32'h200, 22'h010, 32'h0, 4'h0, 4'h0, 1, 32'h1234_5678, 1);

    // Reset clears fault; table reloads from SRAM
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst2.fault", bus.fault, 0);
    chk("rst2.wait", bus.inform_cpu_wait, 1);
    load_phase("load2");

    access("rd_deny", 0, 32'h200, 22'h210, 32'h0, 4'h0, 4'h0, 1, 32'h0, 1);
    access("wr_deny", 0, 32'h200, 22'h201, 32'h1111_1111, 4'hF, 4'h0, 0, 32'h0, 1);
    chk("wr_deny.sram", sram[10'h201], 32'h0);
    access("edge_in", 0, 32'hFC, 22'h23F, 32'h5A5A_5A5A, 4'hF, 4'hF, 0, 32'h0, 1);
    access("data_hi", 0, 32'h200, 22'h240, 32'h0000_0001, 4'hF, 4'hF, 0, 32'h0, 1);
    access("data_lo", 0, 32'h200, 22'h1FF, 32'h0000_0002, 4'hF, 4'hF, 0, 32'h0, 1);
    access("code_hi", 0, 32'h100, 22'h200, 32'h0000_0003, 4'hF, 4'h0, 0, 32'h0, 1);
    chk("code_hi.sram", sram[10'h200], 32'hDEAD_BEEF);

    // Reset during RESP aborts the access and restarts the load
    bus.is_inst   = 1'b0;
    bus.pc_addr   = 32'h40;
    bus.cpu_addr  = 22'h200;
    bus.cpu_wstrb = 4'h0;
    bus.cpu_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst.ready", bus.cpu_ready, 0);
    chk("midrst.wait", bus.inform_cpu_wait, 1);
    chk("midrst.addr", bus.mem_addr, 0);
    chk("midrst.fault", bus.fault, 0);
    bus.cpu_valid = 1'b0;
    load_phase("load3");
    access("after_rst", 0, 32'h40, 22'h200, 32'h0, 4'h0, 4'h0, 1, 32'hDEAD_BEEF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
